// File: rtl/ten_bit_down_counter_pkg.sv
// Shared definitions for the loadable down-counter: FSM state encoding and
// the default count width.
package ten_bit_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ten_bit_down_counter_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on each debounced press (release produces nothing).
module button_debouncer
    import ten_bit_down_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pressed_pulse
);

    logic                     sync1_q, sync2_q;
    logic                     stable_q, stable_d;
    logic                     pulse_q, pulse_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        cnt_d    = '0;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == '1) begin
                stable_d = ~stable_q;
                pulse_d  = ~stable_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pressed_pulse = pulse_q;

endmodule

// File: rtl/ten_bit_down_counter.sv
// Loadable down-counter with optional auto-reload, one-cycle expiry pulse and
// a step input merged from a clean tick and a debounced push button.
module ten_bit_down_counter
    import ten_bit_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter bit          AUTO_RELOAD   = 1'b1,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step_en,
    input  logic             step_btn,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             done_pulse,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             btn_press;
    logic             step;

    button_debouncer #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_debouncer (
        .clock        (clock),
        .reset        (reset),
        .raw          (step_btn),
        .pressed_pulse(btn_press)
    );

    // Coincident tick and button press collapse into a single step.
    assign step = step_en | btn_press;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else if (step && state_q == RUN) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                count_d = '0;
                done_d  = 1'b1;
                state_d = AUTO_RELOAD ? RUN : DONE;
            end else if (AUTO_RELOAD) begin
                count_d = reload_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count      = count_q;
    assign zero       = (count_q == '0);
    assign done_pulse = done_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_ten_bit_down_counter.sv
// Bench for ten_bit_down_counter: an auto-reload and a stop-at-zero instance
// share stimulus and are compared every cycle against an arithmetic model.
module tb_ten_bit_down_counter;

    logic       clock = 1'b0;
    logic       reset, load, step_en, step_btn;
    logic [9:0] load_val;
    logic [9:0] count_a, count_s;
    logic       zero_a, zero_s, done_a, done_s, busy_a, busy_s;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = auto-reload instance, 1 = stop-at-zero instance.
    int m_count[2];
    int m_reload[2];
    bit m_run[2];
    bit m_done[2];

    always #5 clock = ~clock;

    ten_bit_down_counter #(.WIDTH(10), .AUTO_RELOAD(1'b1), .DEBOUNCE_BITS(4)) dut_a (
        .clock(clock), .reset(reset), .load(load), .load_val(load_val),
        .step_en(step_en), .step_btn(step_btn), .count(count_a), .zero(zero_a),
        .done_pulse(done_a), .busy(busy_a)
    );

    ten_bit_down_counter #(.WIDTH(10), .AUTO_RELOAD(1'b0), .DEBOUNCE_BITS(4)) dut_s (
        .clock(clock), .reset(reset), .load(load), .load_val(load_val),
        .step_en(step_en), .step_btn(step_btn), .count(count_s), .zero(zero_s),
        .done_pulse(done_s), .busy(busy_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_reload[k] = 0; m_run[k] = 0; m_done[k] = 0;
        end
    endfunction

    function automatic void model_edge(input bit ld, input int lv, input bit stp);
        for (int k = 0; k < 2; k++) begin
            m_done[k] = 0;
            if (ld) begin
                m_reload[k] = lv;
                m_count[k]  = lv;
                m_run[k]    = (lv != 0);
            end else if (stp && m_run[k]) begin
                if (m_count[k] == 0) begin
                    m_count[k] = m_reload[k];
                end else begin
                    m_count[k] = m_count[k] - 1;
                    if (m_count[k] == 0) begin
                        m_done[k] = 1;
                        m_run[k]  = (k == 0);
                    end
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".a.count"}, 32'(count_a), 32'(m_count[0]));
        check({tag, ".a.zero"},  32'(zero_a),  32'(m_count[0] == 0));
        check({tag, ".a.busy"},  32'(busy_a),  32'(m_run[0]));
        check({tag, ".a.done"},  32'(done_a),  32'(m_done[0]));
        check({tag, ".s.count"}, 32'(count_s), 32'(m_count[1]));
        check({tag, ".s.zero"},  32'(zero_s),  32'(m_count[1] == 0));
        check({tag, ".s.busy"},  32'(busy_s),  32'(m_run[1]));
        check({tag, ".s.done"},  32'(done_s),  32'(m_done[1]));
    endtask

    // One clock: drive inputs, take the edge, advance the model, sample #1 later.
    task automatic tick(input logic ld, input logic [9:0] lv, input logic se,
                        input bit chk, input string tag);
        load = ld; load_val = lv; step_en = se;
        @(posedge clock);
        model_edge(ld, int'(lv), se);
        #1;
        load = 1'b0; step_en = 1'b0;
        if (chk) check_all(tag);
    endtask

    task automatic do_reset(input int cycles, input string tag);
        reset = 1'b1; load = 1'b0; step_en = 1'b0;
        repeat (cycles) @(posedge clock);
        model_reset();
        #1;
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        int         lat;
        logic [9:0] prev;
        logic [9:0] lv;
        logic       ld, se;

        reset = 1'b1; load = 1'b0; load_val = '0; step_en = 1'b0; step_btn = 1'b0;
        model_reset();

        // Reset state, then steps in IDLE are ignored.
        do_reset(2, "reset");
        repeat (3) tick(1'b0, 10'd0, 1'b1, 1'b1, "idle_step");

        // Load 3 then four steps: 3,2,1,0,3 (auto) versus stop at 0.
        tick(1'b1, 10'd3, 1'b0, 1'b1, "load3");
        repeat (4) tick(1'b0, 10'd0, 1'b1, 1'b1, "seq3");
        tick(1'b0, 10'd0, 1'b0, 1'b1, "seq3_hold");

        // Load 2, expire, extra steps ignored by the stopping instance, reload 5.
        tick(1'b1, 10'd2, 1'b0, 1'b1, "load2");
        repeat (4) tick(1'b0, 10'd0, 1'b1, 1'b1, "seq2");
        tick(1'b1, 10'd5, 1'b0, 1'b1, "load5");

        // Load beats a same-cycle step; full-scale value steps normally.
        tick(1'b1, 10'd4, 1'b0, 1'b1, "load4");
        tick(1'b1, 10'd7, 1'b1, 1'b1, "load_vs_step");
        tick(1'b1, 10'd1023, 1'b0, 1'b1, "load_max");
        tick(1'b0, 10'd0, 1'b1, 1'b1, "step_max");

        // Button: short glitches never step.
        tick(1'b1, 10'd6, 1'b0, 1'b1, "load6");
        for (int g = 0; g < 5; g++) begin
            step_btn = 1'b1;
            repeat (8) tick(1'b0, 10'd0, 1'b0, 1'b1, "glitch_hi");
            step_btn = 1'b0;
            repeat (4) tick(1'b0, 10'd0, 1'b0, 1'b1, "glitch_lo");
        end

        // Held press: exactly one step, after sync + debounce latency.
        step_btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            prev = count_a;
            tick(1'b0, 10'd0, 1'b0, 1'b0, "hold");
            if (count_a !== prev) begin
                lat = i;
                break;
            end
        end
        check("btn_latency_in_window", 32'(lat >= 17 && lat <= 20), 32'd1);
        model_edge(1'b0, 0, 1'b1);
        check_all("btn_press");
        repeat (40 - lat) tick(1'b0, 10'd0, 1'b0, 1'b1, "hold_rest");

        // Release never steps.
        step_btn = 1'b0;
        repeat (40) tick(1'b0, 10'd0, 1'b0, 1'b1, "release");

        // Button press and step_en landing on the same edge: single step.
        if (lat > 0) begin
            step_btn = 1'b1;
            for (int i = 1; i < lat; i++) tick(1'b0, 10'd0, 1'b0, 1'b1, "coinc_wait");
            tick(1'b0, 10'd0, 1'b1, 1'b1, "coinc_step");
            repeat (10) tick(1'b0, 10'd0, 1'b0, 1'b1, "coinc_after");
            step_btn = 1'b0;
            repeat (40) tick(1'b0, 10'd0, 1'b0, 1'b1, "coinc_release");
        end

        // Reset while the button is mid-debounce; the held press lands in IDLE.
        tick(1'b1, 10'd6, 1'b0, 1'b1, "load6b");
        step_btn = 1'b1;
        repeat (8) tick(1'b0, 10'd0, 1'b0, 1'b1, "mid_debounce");
        do_reset(1, "reset_mid");
        repeat (40) tick(1'b0, 10'd0, 1'b0, 1'b1, "held_after_reset");
        step_btn = 1'b0;
        repeat (3) tick(1'b0, 10'd0, 1'b1, 1'b1, "idle_after_reset");
        tick(1'b1, 10'd2, 1'b0, 1'b1, "reload_after_reset");

        // Random loads and steps, checked every cycle.
        for (int r = 0; r < 400; r++) begin
            ld = ($urandom_range(0, 11) == 0);
            se = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0:       lv = 10'd1023;
                1:       lv = 10'($urandom);
                default: lv = 10'($urandom_range(0, 5));
            endcase
            tick(ld, lv, se, 1'b1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
